// File: rtl/mem_load_unit_pkg.sv
// Shared types and encodings for the MEM-stage load path: load type, bus size codes,
// FSM state codes and small decode helpers.
package mem_load_unit_pkg;

  // {ReadMem, sign, size}; size 00=word, 01=half, 10=byte
  typedef struct packed {
    logic       read_mem;
    logic       sign;
    logic [1:0] size;
  } load_type_t;

  localparam logic [1:0] LOADTYPE_LW = 2'b00;
  localparam logic [1:0] LOADTYPE_LH = 2'b01;
  localparam logic [1:0] LOADTYPE_LB = 2'b10;

  localparam logic [1:0] DSIZE_BYTE = 2'd0;
  localparam logic [1:0] DSIZE_HALF = 2'd1;
  localparam logic [1:0] DSIZE_WORD = 2'd2;

  typedef logic [2:0] load_state_t;

  localparam load_state_t LD_IDLE  = 3'd0;
  localparam load_state_t LD_REQ   = 3'd1;
  localparam load_state_t LD_WAIT  = 3'd2;
  localparam load_state_t LD_DONE  = 3'd3;
  localparam load_state_t LD_DRAIN = 3'd4;

  function automatic logic [1:0] to_data_size(logic [1:0] size);
    case (size)
      LOADTYPE_LH: to_data_size = DSIZE_HALF;
      LOADTYPE_LB: to_data_size = DSIZE_BYTE;
      default:     to_data_size = DSIZE_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(logic [1:0] size, logic [1:0] addr_lo);
    is_misaligned = ((size == LOADTYPE_LW) && (addr_lo != 2'b00)) ||
                    ((size == LOADTYPE_LH) && addr_lo[0]);
  endfunction

endpackage

// File: rtl/mem_load_unit_if.sv
// SRAM-like data bus, read side. The load unit is the master; memory is the slave.
interface mem_load_unit_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_load_unit_extract.sv
// Combinational lane select and sign/zero extension of a returned read word.
module load_extract
  import mem_load_unit_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (addr_i)
      2'd0:    byte_lane = rdata_i[7:0];
      2'd1:    byte_lane = rdata_i[15:8];
      2'd2:    byte_lane = rdata_i[23:16];
      default: byte_lane = rdata_i[31:24];
    endcase
    half_lane = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (size_i)
      LOADTYPE_LB: result_o = {{24{sign_i & byte_lane[7]}}, byte_lane};
      LOADTYPE_LH: result_o = {{16{sign_i & half_lane[15]}}, half_lane};
      default:     result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_load_unit.sv
// MEM-stage load unit: issues reads on the data bus, stalls until the response returns,
// then registers the aligned, extended result. Flushed loads are drained, never reported.
module mem_load_unit
  import mem_load_unit_pkg::*;
#(
  parameter bit WORD_ACCESS = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   MEM_Valid,
  input  logic                   MEM_Flush,
  input  logic [31:0]            MEM_ALUOut,
  input  load_type_t             MEM_LoadType,
  output logic                   MEM_Stall,
  output logic                   MEM_LoadDone,
  output logic [31:0]            MEM_DMOut,
  mem_load_unit_if.master        bus
);

  load_state_t state_q, state_d;
  logic        kill_q, kill_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic [31:0] dmout_q, dmout_d;

  logic        misaligned;
  logic        start;
  logic [31:0] extracted;

  load_extract u_extract (
    .rdata_i  (bus.data_rdata),
    .addr_i   (addr_q[1:0]),
    .size_i   (size_q),
    .sign_i   (sign_q),
    .result_o (extracted)
  );

  assign misaligned = is_misaligned(MEM_LoadType.size, MEM_ALUOut[1:0]);
  assign start      = MEM_Valid & MEM_LoadType.read_mem & ~misaligned & ~MEM_Flush &
                      (state_q == LD_IDLE);

  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    addr_d  = addr_q;
    size_d  = size_q;
    sign_d  = sign_q;
    dmout_d = dmout_q;

    case (state_q)
      LD_IDLE: begin
        if (start) begin
          state_d = LD_REQ;
          kill_d  = 1'b0;
          addr_d  = MEM_ALUOut;
          size_d  = MEM_LoadType.size;
          sign_d  = MEM_LoadType.sign;
        end
      end
      LD_REQ: begin
        // The request cannot be withdrawn; a flush only marks it for discard.
        kill_d = kill_q | MEM_Flush;
        if (bus.data_addr_ok) begin
          state_d = (kill_q | MEM_Flush) ? LD_DRAIN : LD_WAIT;
        end
      end
      LD_WAIT: begin
        if (bus.data_data_ok) begin
          state_d = LD_IDLE;
          kill_d  = 1'b0;
          if (!(kill_q | MEM_Flush)) begin
            state_d = LD_DONE;
            dmout_d = extracted;
          end
        end else if (MEM_Flush) begin
          state_d = LD_DRAIN;
        end
      end
      LD_DRAIN: begin
        if (bus.data_data_ok) begin
          state_d = LD_IDLE;
          kill_d  = 1'b0;
        end
      end
      LD_DONE: state_d = LD_IDLE;
      default: state_d = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LD_IDLE;
      kill_q  <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      sign_q  <= 1'b0;
      dmout_q <= '0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      dmout_q <= dmout_d;
    end
  end

  assign bus.data_req  = (state_q == LD_REQ);
  assign bus.data_wr   = 1'b0;
  assign bus.data_addr = WORD_ACCESS ? {addr_q[31:2], 2'b00} : addr_q;
  assign bus.data_size = WORD_ACCESS ? DSIZE_WORD : to_data_size(size_q);

  assign MEM_Stall    = (state_q == LD_REQ) | (state_q == LD_WAIT) | (state_q == LD_DRAIN) |
                        start;
  assign MEM_LoadDone = (state_q == LD_DONE);
  assign MEM_DMOut    = dmout_q;

endmodule

// File: tb/tb_mem_load_unit.sv
// Directed bench for mem_load_unit: a table of single loads plus hand-written flush,
// misaligned and reset sequences.
module tb_mem_load_unit;
  import mem_load_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_Valid;
  logic        MEM_Flush;
  logic [31:0] MEM_ALUOut;
  load_type_t  MEM_LoadType;
  logic        MEM_Stall;
  logic        MEM_LoadDone;
  logic [31:0] MEM_DMOut;

  mem_load_unit_if bus ();

  mem_load_unit #(
    .WORD_ACCESS (1'b0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .MEM_Valid    (MEM_Valid),
    .MEM_Flush    (MEM_Flush),
    .MEM_ALUOut   (MEM_ALUOut),
    .MEM_LoadType (MEM_LoadType),
    .MEM_Stall    (MEM_Stall),
    .MEM_LoadDone (MEM_LoadDone),
    .MEM_DMOut    (MEM_DMOut),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic load_type_t mk_lt(input logic sign, input logic [1:0] size);
    load_type_t lt;
    lt.read_mem = 1'b1;
    lt.sign     = sign;
    lt.size     = size;
    return lt;
  endfunction

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        sign;
    logic [1:0]  size;
    logic [31:0] rdata;
    logic [1:0]  exp_size;
    logic [31:0] exp_out;
  } vec_t;

  vec_t vecs[8];

  // Drives one load starting at the next cycle and plays the memory side: addr_ok after
  // ok_delay request cycles, data_ok on the cycle after acceptance. Cycle 0 is the start cycle.
  task automatic run_load(input logic [31:0] addr, input load_type_t lt, input logic [31:0] rdata,
                          input int ok_delay, input int limit, output int done_cyc,
                          output logic [31:0] req_mask, output logic [31:0] stall_mask,
                          output logic [31:0] req_addr, output logic [1:0] req_size,
                          output logic addr_moved);
    int   req_n;
    logic pend;
    req_n = 0; pend = 1'b0; done_cyc = -1;
    req_mask = '0; stall_mask = '0; req_addr = '0; req_size = '0; addr_moved = 1'b0;
    @(posedge clk); #1;
    MEM_Valid = 1'b1; MEM_ALUOut = addr; MEM_LoadType = lt; bus.data_rdata = rdata;
    for (int c = 0; c < limit; c++) begin
      bus.data_addr_ok = bus.data_req && (req_n >= ok_delay);
      bus.data_data_ok = pend;
      @(negedge clk);
      if (bus.data_req) begin
        req_mask[c] = 1'b1;
        if (req_n == 0) begin
          req_addr = bus.data_addr;
          req_size = bus.data_size;
        end else if (bus.data_addr !== req_addr || bus.data_size !== req_size) begin
          addr_moved = 1'b1;
        end
        req_n++;
      end
      if (MEM_Stall) stall_mask[c] = 1'b1;
      if (MEM_LoadDone) done_cyc = c;
      if (bus.data_addr_ok) pend = 1'b1;
      else if (bus.data_data_ok) pend = 1'b0;
      @(posedge clk); #1;
      if (done_cyc >= 0) break;
    end
    MEM_Valid = 1'b0; bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
  endtask

  initial begin
    int          done_cyc;
    logic [31:0] req_mask, stall_mask, req_addr;
    logic [1:0]  req_size;
    logic        moved;
    logic [31:0] prev_out;

    vecs[0] = '{"lw_100",  32'h100, 1'b0, LOADTYPE_LW, 32'hDEADBEEF, DSIZE_WORD, 32'hDEADBEEF};
    vecs[1] = '{"lb_103",  32'h103, 1'b1, LOADTYPE_LB, 32'h80FF0011, DSIZE_BYTE, 32'hFFFFFF80};
    vecs[2] = '{"lbu_103", 32'h103, 1'b0, LOADTYPE_LB, 32'h80FF0011, DSIZE_BYTE, 32'h00000080};
    vecs[3] = '{"lh_102",  32'h102, 1'b1, LOADTYPE_LH, 32'h80017FFF, DSIZE_HALF, 32'hFFFF8001};
    vecs[4] = '{"lhu_100", 32'h100, 1'b0, LOADTYPE_LH, 32'h80017FFF, DSIZE_HALF, 32'h00007FFF};
    vecs[5] = '{"lb_101",  32'h101, 1'b1, LOADTYPE_LB, 32'h0000AB00, DSIZE_BYTE, 32'hFFFFFFAB};
    vecs[6] = '{"lhu_102", 32'h102, 1'b0, LOADTYPE_LH, 32'h80017FFF, DSIZE_HALF, 32'h00008001};
    vecs[7] = '{"lb_100",  32'h100, 1'b1, LOADTYPE_LB, 32'h80FF0011, DSIZE_BYTE, 32'h00000011};

    rst = 1'b1; MEM_Valid = 1'b0; MEM_Flush = 1'b0; MEM_ALUOut = '0; MEM_LoadType = '0;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check32("reset data_req", {31'b0, bus.data_req}, 32'h0);
    check32("reset data_wr", {31'b0, bus.data_wr}, 32'h0);
    check32("reset stall", {31'b0, MEM_Stall}, 32'h0);
    check32("reset loaddone", {31'b0, MEM_LoadDone}, 32'h0);
    check32("reset dmout", MEM_DMOut, 32'h0);
    check32("reset data_addr", bus.data_addr, 32'h0);

    for (int i = 0; i < 8; i++) begin
      run_load(vecs[i].addr, mk_lt(vecs[i].sign, vecs[i].size), vecs[i].rdata, 0, 20,
               done_cyc, req_mask, stall_mask, req_addr, req_size, moved);
      check32({vecs[i].name, " done_cycle"}, done_cyc, 32'd3);
      check32({vecs[i].name, " req_cycles"}, req_mask, 32'h2);
      check32({vecs[i].name, " stall_cycles"}, stall_mask, 32'h7);
      check32({vecs[i].name, " data_addr"}, req_addr, vecs[i].addr);
      check32({vecs[i].name, " data_size"}, {30'b0, req_size}, {30'b0, vecs[i].exp_size});
      check32({vecs[i].name, " dmout"}, MEM_DMOut, vecs[i].exp_out);
    end
    prev_out = vecs[7].exp_out;

    // Misaligned word load is never issued.
    run_load(32'h102, mk_lt(1'b0, LOADTYPE_LW), 32'h12345678, 0, 6,
             done_cyc, req_mask, stall_mask, req_addr, req_size, moved);
    check32("misaligned req", req_mask, 32'h0);
    check32("misaligned stall", stall_mask, 32'h0);
    check32("misaligned done", done_cyc, 32'hFFFFFFFF);
    check32("misaligned dmout", MEM_DMOut, prev_out);

    // addr_ok after 3 request cycles, flush in WAIT, data_ok two cycles later.
    @(posedge clk); #1;
    MEM_Valid = 1'b1; MEM_ALUOut = 32'h200; MEM_LoadType = mk_lt(1'b0, LOADTYPE_LW);
    bus.data_rdata = 32'hCAFEF00D;
    @(negedge clk);
    check32("flush c0 stall", {31'b0, MEM_Stall}, 32'h1);
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      bus.data_addr_ok = (c == 3);
      @(negedge clk);
      check32($sformatf("flush c%0d req", c), {31'b0, bus.data_req}, 32'h1);
      check32($sformatf("flush c%0d addr", c), bus.data_addr, 32'h200);
      check32($sformatf("flush c%0d size", c), {30'b0, bus.data_size}, {30'b0, DSIZE_WORD});
      check32($sformatf("flush c%0d stall", c), {31'b0, MEM_Stall}, 32'h1);
    end
    @(posedge clk); #1;
    bus.data_addr_ok = 1'b0; MEM_Flush = 1'b1; MEM_Valid = 1'b0;
    @(negedge clk);
    check32("flush c4 req", {31'b0, bus.data_req}, 32'h0);
    check32("flush c4 stall", {31'b0, MEM_Stall}, 32'h1);
    @(posedge clk); #1;
    MEM_Flush = 1'b0;
    @(negedge clk);
    check32("flush c5 stall", {31'b0, MEM_Stall}, 32'h1);
    check32("flush c5 req", {31'b0, bus.data_req}, 32'h0);
    @(posedge clk); #1;
    bus.data_data_ok = 1'b1;
    @(negedge clk);
    check32("flush c6 stall", {31'b0, MEM_Stall}, 32'h1);
    check32("flush c6 done", {31'b0, MEM_LoadDone}, 32'h0);
    @(posedge clk); #1;
    bus.data_data_ok = 1'b0;
    @(negedge clk);
    check32("flush c7 stall", {31'b0, MEM_Stall}, 32'h0);
    check32("flush c7 done", {31'b0, MEM_LoadDone}, 32'h0);
    check32("flush dmout", MEM_DMOut, prev_out);

    // Reset while waiting for data; bus side is reset in the same cycle.
    @(posedge clk); #1;
    MEM_Valid = 1'b1; MEM_ALUOut = 32'h300; MEM_LoadType = mk_lt(1'b0, LOADTYPE_LW);
    bus.data_rdata = 32'h55AA55AA;
    @(posedge clk); #1;
    bus.data_addr_ok = 1'b1;
    @(negedge clk);
    check32("rst seq req", {31'b0, bus.data_req}, 32'h1);
    @(posedge clk); #1;
    bus.data_addr_ok = 1'b0; rst = 1'b1; MEM_Valid = 1'b0;
    @(negedge clk);
    check32("rst seq wait stall", {31'b0, MEM_Stall}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check32("post-rst req", {31'b0, bus.data_req}, 32'h0);
    check32("post-rst stall", {31'b0, MEM_Stall}, 32'h0);
    check32("post-rst done", {31'b0, MEM_LoadDone}, 32'h0);
    check32("post-rst dmout", MEM_DMOut, 32'h0);

    run_load(32'h1, mk_lt(1'b0, LOADTYPE_LB), 32'h0000AB00, 0, 20,
             done_cyc, req_mask, stall_mask, req_addr, req_size, moved);
    check32("lbu_1 done_cycle", done_cyc, 32'd3);
    check32("lbu_1 dmout", MEM_DMOut, 32'h000000AB);
    check32("lbu_1 data_addr", req_addr, 32'h1);

    // A slow slave: addr_ok on the 3rd request cycle, request must not move meanwhile.
    run_load(32'h104, mk_lt(1'b1, LOADTYPE_LH), 32'hFFFF0123, 2, 20,
             done_cyc, req_mask, stall_mask, req_addr, req_size, moved);
    check32("slow lh done_cycle", done_cyc, 32'd5);
    check32("slow lh req_cycles", req_mask, 32'hE);
    check32("slow lh addr stable", {31'b0, moved}, 32'h0);
    check32("slow lh dmout", MEM_DMOut, 32'h00000123);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
